posit_mant_div_seq: RTL and testbench

// - Sequential restoring divider for posit significands; sits directly upstream of the rounding stage.
// - Takes decoded dividend/divisor significands (hidden bit at MSB).
// - Produces the normalised 2N-bit quotient significand (Div_Mant_N format) and a normalise flag.
//   The exponent stage uses the flag to decrement the combined exponent.
// - One quotient bit per cycle; valid/ready on both sides; zero/inf operands bypass the datapath.

---
 rtl/posit_mant_div_seq.sv | 197 +++++++++++++++++++
 tb/tb_posit_mant_div_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_mant_div_seq.sv
// Sequential restoring divider for posit significands.
// Produces one quotient bit per cycle and delivers a normalised 2N-bit
// quotient significand with a sticky LSB and a normalise-decrement flag.
// Zero/NaR/invalid-divisor operands skip the iteration and finish in one step.
module posit_mant_div_seq #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   Mant1,
  input  logic [N-1:0]   Mant2,
  input  logic           Sign_in,
  input  logic           zero_in,
  input  logic           inf_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] Div_Mant_N,
  output logic           norm_dec,
  output logic           Sign,
  output logic           zero,
  output logic           inf
);

  localparam int CW = $clog2(2*N+2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;

  logic [N:0]       rem_r;
  logic [N-1:0]     mant2_r;
  // Only the low 2N quotient bits are stored: the top bit of the 2N+1-bit
  // quotient appears on the final iteration and is consumed directly from
  // the next-value path when the result is registered.
  logic [2*N-1:0]   q_r;
  logic [CW-1:0]    cnt_r;

  logic             in_ready_r;
  logic             out_valid_r;
  logic [2*N-1:0]   div_mant_r;
  logic             norm_dec_r;
  logic             sign_r;
  logic             zero_r;
  logic             inf_r;

  logic [N+1:0]     diff_s;
  logic             ge_s;
  logic [N:0]       rem_nxt_s;
  logic [2*N:0]     q_nxt_s;
  logic             rem_nz_s;
  logic [2*N-1:0]   res_s;
  logic             res_nd_s;
  logic             last_s;
  logic             bypass_s;

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign Div_Mant_N = div_mant_r;
  assign norm_dec   = norm_dec_r;
  assign Sign       = sign_r;
  assign zero       = zero_r;
  assign inf        = inf_r;

  assign bypass_s = zero_in | inf_in | ~Mant2[N-1];
  assign last_s   = (cnt_r == CW'(2*N));

  // One restoring step plus normalisation of the would-be final quotient.
  always_comb begin
    diff_s   = {1'b0, rem_r} - {2'b00, mant2_r};
    ge_s     = ~diff_s[N+1];
    if (ge_s) begin
      rem_nxt_s = diff_s[N:0] << 1;
    end else begin
      rem_nxt_s = rem_r << 1;
    end
    q_nxt_s  = {q_r, ge_s};
    rem_nz_s = |rem_nxt_s;
    if (q_nxt_s[2*N]) begin
      res_s    = q_nxt_s[2*N:1];
      res_s[0] = q_nxt_s[1] | q_nxt_s[0] | rem_nz_s;
      res_nd_s = 1'b0;
    end else begin
      res_s    = q_nxt_s[2*N-1:0];
      res_s[0] = q_nxt_s[0] | rem_nz_s;
      res_nd_s = 1'b1;
    end
  end

  // Next-state logic for the IDLE -> CALC -> DONE -> IDLE sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (bypass_s) begin
            state_s = DONE;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Handshake flags registered from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand capture, iteration datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_r      <= {(N+1){1'b0}};
      mant2_r    <= {N{1'b0}};
      q_r        <= {(2*N){1'b0}};
      cnt_r      <= {CW{1'b0}};
      div_mant_r <= {(2*N){1'b0}};
      norm_dec_r <= 1'b0;
      sign_r     <= 1'b0;
      zero_r     <= 1'b0;
      inf_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            rem_r      <= {1'b0, Mant1};
            mant2_r    <= Mant2;
            q_r        <= {(2*N){1'b0}};
            cnt_r      <= {CW{1'b0}};
            div_mant_r <= {(2*N){1'b0}};
            norm_dec_r <= 1'b0;
            sign_r     <= Sign_in;
            zero_r     <= zero_in;
            // A divisor without its hidden bit cannot be a valid nonzero
            // significand, so it is flagged as an invalid result.
            inf_r      <= inf_in | ~Mant2[N-1];
          end
        end
        CALC: begin
          rem_r <= rem_nxt_s;
          q_r   <= q_nxt_s[2*N-1:0];
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (last_s) begin
            div_mant_r <= res_s;
            norm_dec_r <= res_nd_s;
          end
        end
        DONE: begin
          div_mant_r <= div_mant_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posit_mant_div_seq.sv
// Self-checking bench for posit_mant_div_seq: directed cases with literal
// expectations, randomized operands against a wide-integer division model.
module tb_posit_mant_div_seq;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  Mant1 = '0;
  logic [N-1:0]  Mant2 = '0;
  logic          Sign_in = 1'b0;
  logic          zero_in = 1'b0;
  logic          inf_in = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2*N-1:0] Div_Mant_N;
  logic          norm_dec;
  logic          Sign;
  logic          zero;
  logic          inf;

  posit_mant_div_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .Mant1(Mant1), .Mant2(Mant2),
    .Sign_in(Sign_in), .zero_in(zero_in), .inf_in(inf_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .Div_Mant_N(Div_Mant_N), .norm_dec(norm_dec),
    .Sign(Sign), .zero(zero), .inf(inf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] mant;
    logic        nd;
    logic        s;
    logic        z;
    logic        i;
    logic        byp;
    int          acc;
  } exp_t;

  exp_t expq[$];
  exp_t ce;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Quotient of significands as a 64-bit fixed-point fraction, from plain
  // wide-integer division: q = floor(m1 * 2^64 / m2), 65 significant bits.
  function automatic exp_t model(input logic [31:0] m1, input logic [31:0] m2,
                                 input logic s, input logic z, input logic i);
    exp_t e;
    logic [127:0] num, quo, rmd;
    e.s = s; e.z = z; e.i = i | ~m2[31]; e.acc = 0;
    e.byp = z | i | ~m2[31];
    e.mant = 64'd0; e.nd = 1'b0;
    if (!e.byp) begin
      num = {32'd0, m1, 64'd0};
      quo = num / {96'd0, m2};
      rmd = num % {96'd0, m2};
      if (quo[64]) begin
        e.mant = quo[64:1];
        if (quo[0] || rmd != 128'd0) e.mant[0] = 1'b1;
      end else begin
        e.mant = quo[63:0];
        e.nd = 1'b1;
        if (rmd != 128'd0) e.mant[0] = 1'b1;
      end
    end
    return e;
  endfunction

  function automatic exp_t mk(input logic [63:0] mant, input logic nd, input logic s,
                              input logic z, input logic i, input logic byp);
    exp_t e;
    e.mant = mant; e.nd = nd; e.s = s; e.z = z; e.i = i; e.byp = byp; e.acc = 0;
    return e;
  endfunction

  // Per-cycle comparison of the DUT outputs against the expected-result queue.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, (expq.size() == 0)});
      if (out_valid) begin
        if (expq.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL spurious_out_valid: got 1, required 0 (t=%0t)", $time);
        end else begin
          ce = expq[0];
          chk("Div_Mant_N", Div_Mant_N, ce.mant);
          chk("norm_dec", {63'd0, norm_dec}, {63'd0, ce.nd});
          chk("Sign", {63'd0, Sign}, {63'd0, ce.s});
          chk("zero", {63'd0, zero}, {63'd0, ce.z});
          chk("inf", {63'd0, inf}, {63'd0, ce.i});
          // Latency counts the accept edge as cycle 1.
          if (!prev_valid)
            chk("latency", 64'(cyc - ce.acc + 1), ce.byp ? 64'd1 : 64'd66);
          if (out_ready) void'(expq.pop_front());
        end
      end
      prev_valid = out_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic do_op(input logic [31:0] m1, input logic [31:0] m2, input logic s,
                       input logic z, input logic i, input exp_t e, input int hold);
    int held;
    @(posedge clk); #1;
    Mant1 = m1; Mant2 = m2; Sign_in = s; zero_in = z; inf_in = i;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    e.acc = cyc;
    expq.push_back(e);
    // Scramble the operand bus: the captured values must be used.
    Mant1 = $urandom; Mant2 = $urandom;
    Sign_in = 1'($urandom); zero_in = 1'($urandom); inf_in = 1'($urandom);
    in_valid = 1'($urandom_range(0, 1));
    held = 0;
    for (int k = 0; k < 300 && expq.size() != 0; k++) begin
      if (out_valid) begin
        if (held >= hold) out_ready = 1'b1;
        held++;
      end
      @(posedge clk); #1;
    end
    if (expq.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL timeout: no result after 300 cycles, required a handshake");
      expq.delete();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic reset_during(input int wait_cycles, input logic [31:0] m1, input logic [31:0] m2);
    exp_t e;
    e = model(m1, m2, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    Mant1 = m1; Mant2 = m2; Sign_in = 1'b0; zero_in = 1'b0; inf_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    e.acc = cyc;
    expq.push_back(e);
    in_valid = 1'b0;
    repeat (wait_cycles) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_div_mant", Div_Mant_N, 64'd0);
    expq.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [31:0] a, b;
    logic s, z, i;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
    chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
    chk("reset_div_mant", Div_Mant_N, 64'd0);
    chk("reset_flags", {60'd0, norm_dec, Sign, zero, inf}, 64'd0);
    rst_n = 1'b1;

    // Pin the reference model against hand-computed quotients.
    e = model(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    chk("model_1_over_1", {e.mant[63:1], e.nd}, {63'h4000_0000_0000_0000, 1'b0});
    e = model(32'h8000_0000, 32'hC000_0000, 1'b0, 1'b0, 1'b0);
    chk("model_1_over_1p5", {e.mant[63:1], e.nd}, {63'h5555_5555_5555_5555, 1'b1});
    chk("model_1_over_1p5_lsb", e.mant, 64'hAAAA_AAAA_AAAA_AAAB);
    e = model(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    chk("model_max_over_1", e.mant, 64'hFFFF_FFFF_0000_0000);

    // Directed divisions with literal expectations.
    do_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0,
          mk(64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 0);
    do_op(32'h8000_0000, 32'hC000_0000, 1'b1, 1'b0, 1'b0,
          mk(64'hAAAA_AAAA_AAAA_AAAB, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 0);
    do_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1'b0,
          mk(64'hFFFF_FFFF_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0), 1);

    // Bypass paths: zero dividend, NaR, divisor without hidden bit.
    do_op(32'h9000_0000, 32'hA000_0000, 1'b1, 1'b1, 1'b0,
          mk(64'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1), 0);
    do_op(32'h9000_0000, 32'hA000_0000, 1'b0, 1'b0, 1'b1,
          mk(64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1), 2);
    do_op(32'h9000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b0,
          mk(64'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1), 0);

    // Back-pressure: result held for ten cycles before acceptance.
    e = model(32'hB504_F333, 32'hD000_0001, 1'b1, 1'b0, 1'b0);
    do_op(32'hB504_F333, 32'hD000_0001, 1'b1, 1'b0, 1'b0, e, 10);

    // Asynchronous reset in the middle of iteration and while holding a result.
    reset_during(20, 32'hC000_0000, 32'h8000_0001);
    e = model(32'hC000_0000, 32'h8000_0001, 1'b0, 1'b0, 1'b0);
    do_op(32'hC000_0000, 32'h8000_0001, 1'b0, 1'b0, 1'b0, e, 0);
    reset_during(70, 32'hF000_0000, 32'h9000_0000);
    e = model(32'hF000_0000, 32'h9000_0000, 1'b0, 1'b0, 1'b0);
    do_op(32'hF000_0000, 32'h9000_0000, 1'b0, 1'b0, 1'b0, e, 0);

    // Randomized operands, mostly normal significands.
    for (int n = 0; n < 40; n++) begin
      a = $urandom | 32'h8000_0000;
      b = $urandom;
      if ($urandom_range(0, 7) != 0) b = b | 32'h8000_0000;
      if ($urandom_range(0, 5) == 0) b = 32'h8000_0000;
      s = 1'($urandom);
      z = ($urandom_range(0, 9) == 0);
      i = ($urandom_range(0, 9) == 0);
      e = model(a, b, s, z, i);
      do_op(a, b, s, z, i, e, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
